// File: rtl/onehot_decoder_if.sv
// Stream bundle for the one-hot decoder: index input, one-hot output,
// and the out-of-range error counter side channel.
//
// Handshake: a beat moves across a channel on a rising clk edge where
// valid && ready are both high. A source keeps valid and payload stable
// until the transfer. in_ready depends only on the decoder's buffer
// occupancy, never combinationally on in_valid or out_ready.
interface onehot_decoder_if #(
  parameter int N_OUT = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_onehot;
  logic             out_err;
  logic             clr_count;
  logic [CNT_W-1:0] err_count;

  // Control source / consumer side
  modport master (
    output in_valid, in_idx, out_ready, clr_count,
    input  in_ready, out_valid, out_onehot, out_err, err_count
  );

  // Decoder side
  modport slave (
    input  in_valid, in_idx, out_ready, clr_count,
    output in_ready, out_valid, out_onehot, out_err, err_count
  );
endinterface

// File: rtl/onehot_decoder.sv
// Binary index to one-hot decoder with a 2-entry output buffer.
// The head entry drives the outputs straight from registers. An index
// >= N_OUT is stored as onehot=0, err=1 and bumps a saturating counter.
module onehot_decoder #(
  parameter int N_OUT = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  onehot_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       occ, occ_nxt;
  logic [N_OUT-1:0] head_oh, head_oh_nxt;
  logic [N_OUT-1:0] tail_oh, tail_oh_nxt;
  logic             head_err, head_err_nxt;
  logic             tail_err, tail_err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_OUT-1:0] dec_oh;
  logic             dec_err;
  logic             push, pop;

  // Decode the incoming index; out-of-range indices give an all-zero word
  always_comb begin
    dec_oh = '0;
    for (int i = 0; i < N_OUT; i++) begin
      dec_oh[i] = (int'(bus.in_idx) == i);
    end
    dec_err = (int'(bus.in_idx) >= N_OUT);
  end

  // Held low during reset so nothing is accepted into a buffer being flushed
  assign bus.in_ready   = !rst && (occ != 2'd2);
  assign bus.out_valid  = (occ != 2'd0);
  assign bus.out_onehot = head_oh;
  assign bus.out_err    = head_err;
  assign bus.err_count  = cnt;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Next buffer contents; the head is cleared when the buffer drains so
  // the outputs read zero while out_valid is low
  always_comb begin
    occ_nxt      = occ;
    head_oh_nxt  = head_oh;
    head_err_nxt = head_err;
    tail_oh_nxt  = tail_oh;
    tail_err_nxt = tail_err;
    case ({push, pop})
      2'b10: begin
        occ_nxt = occ + 2'd1;
        if (occ == 2'd0) begin
          head_oh_nxt  = dec_oh;
          head_err_nxt = dec_err;
        end else begin
          tail_oh_nxt  = dec_oh;
          tail_err_nxt = dec_err;
        end
      end
      2'b01: begin
        occ_nxt      = occ - 2'd1;
        tail_oh_nxt  = '0;
        tail_err_nxt = 1'b0;
        if (occ == 2'd2) begin
          head_oh_nxt  = tail_oh;
          head_err_nxt = tail_err;
        end else begin
          head_oh_nxt  = '0;
          head_err_nxt = 1'b0;
        end
      end
      2'b11: begin
        if (occ == 2'd2) begin
          head_oh_nxt  = tail_oh;
          head_err_nxt = tail_err;
          tail_oh_nxt  = dec_oh;
          tail_err_nxt = dec_err;
        end else begin
          head_oh_nxt  = dec_oh;
          head_err_nxt = dec_err;
        end
      end
      default: ;
    endcase
  end

  // Error counter: a clear in the same cycle as a bad beat still counts that beat
  always_comb begin
    cnt_nxt = cnt;
    if (bus.clr_count) begin
      cnt_nxt = (push && dec_err) ? CNT_W'(1) : '0;
    end else if (push && dec_err && cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // State registers; reset discards any held beats
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      head_oh  <= '0;
      head_err <= 1'b0;
      tail_oh  <= '0;
      tail_err <= 1'b0;
      cnt      <= '0;
    end else begin
      occ      <= occ_nxt;
      head_oh  <= head_oh_nxt;
      head_err <= head_err_nxt;
      tail_oh  <= tail_oh_nxt;
      tail_err <= tail_err_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule
